md_unit: RTL
============

Name: md_unit

Overview:
- Execute-stage multiply/divide unit that owns the HI/LO register pair.
- It is the write end of HI/LO; mfhi/mflo (the reader side) take `hi`/`lo` and the writeback path commits them to the GPR file.
- Accepts one operation per `start` pulse and asserts `busy` for a fixed multi-cycle latency.
- D-stage hazard logic stalls any HI/LO-class instruction while `start | busy`.

Parameters:
- MULT_CYCLES, 5, cycles `busy` is held for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (range 1..15).
- DIV_CYCLES, 10, cycles `busy` is held for DIV/DIVU (range 1..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; `op`, `a`, `b` are sampled when high
- op  input  4  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10-15 reserved
- a  input  32  rs operand, forwarded value
- b  input  32  rt operand, forwarded value
- busy  output  1  multi-cycle operation in flight
- hi  output  32  architectural HI
- lo  output  32  architectural LO
- flush  input  1  present only with MD_FLUSH_EN

Behaviour:
- Reset (reset=0, asynchronous): `hi`=0, `lo`=0, `busy`=0, state=IDLE, counter=0, pending result=0.
- States:
  - IDLE → RUN on `start` with a multi-cycle op.
  - RUN → IDLE when the counter reaches 1.
- Multi-cycle op accepted at edge T:
  - result computed from `a`, `b`, and the current `hi`/`lo`; stored in pending {phi,plo}.
  - counter loaded with MULT_CYCLES or DIV_CYCLES.
  - `busy`=1 from T through T+N-1.
- Each RUN cycle decrements the counter. At the edge where it reaches 1:
  - {hi,lo} ← {phi,plo}, `busy` ← 0.
  - New values are visible at T+N, the same cycle `busy` drops.
- `hi`/`lo` never change while `busy`=1.
- MTHI/MTLO:
  - `hi`←`a` or `lo`←`a` at the accepting edge; no `busy`.
  - The other register is unchanged.
- Reserved op with `start`: no effect.
- `start` while `busy`=1 or in RUN: ignored, no state change. Upstream must stall; the bench flags this as a protocol violation.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 → 64-bit product.
  - MULTU: {hi,lo} = unsigned 32x32 → 64-bit product.
  - MADD/MADDU: {hi,lo} + product (signed or unsigned), 64-bit wrap-around, no overflow flag.
  - MSUB/MSUBU: {hi,lo} − product, 64-bit wrap-around.
  - DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (b=0, DIV or DIVU): accepted, `busy` held DIV_CYCLES; {hi,lo} unchanged at completion.
- Accumulate base is {hi,lo} sampled at acceptance. This is valid because no HI/LO write can occur while `busy`.
- Reset asserted mid-RUN: immediate abort; all outputs return to reset values; the pending result is discarded.
- The block has no combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: MD_FLUSH_EN. When defined, adds the `flush` input (exception/interrupt at E stage).
- flush=1 in RUN:
  - aborts the op at the next edge: `busy`←0, state←IDLE.
  - pending result discarded; `hi`/`lo` keep their pre-op values.
- flush=1 together with `start`: the request is dropped, including MTHI/MTLO.
- flush has priority over completion in the same cycle.
- Undefined: no `flush` port exists; every accepted op completes.

Test Plan:
- Reset, then MULT with a=0xFFFFFFFE (−2), b=3 → `busy` high 5 cycles; at T+5 hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo stay 0 during busy.
- DIV with a=0xFFFFFFF9 (−7), b=2 → `busy` 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with a=7, b=0 → `busy` 10 cycles; hi/lo unchanged.
- MTHI with a=0x00000001 then MTLO with a=0xFFFFFFFF; then MADDU with a=1, b=1 → after 5 cycles hi=0x00000002, lo=0x00000000 (carry into hi).
- MULTU with a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. `start`+MTLO issued at cycle 2 of busy → ignored; lo unchanged at completion.
- reset pulled low at cycle 3 of a DIV → `busy`, hi, lo read 0 immediately (asynchronous); no later update after reset releases.
- MD_FLUSH_EN: preload lo=0x12345678; MULT a=2, b=2 with flush at cycle 2 → `busy`=0 next cycle, lo=0x12345678, hi unchanged.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit owning the HI/LO pair.
//
// One operation is accepted per start pulse. Multi-cycle ops (MULT/MULTU,
// MADD/MADDU, MSUB/MSUBU, DIV/DIVU) compute their result at the accepting
// edge into a pending register. busy is held for MULT_CYCLES or DIV_CYCLES
// cycles, then the pending value is committed to HI/LO. MTHI/MTLO write
// immediately without raising busy.
//
// Optional build macro: MD_FLUSH_EN adds the flush input. flush aborts an
// in-flight op (HI/LO keep their pre-op values) and drops a request
// presented in the same cycle.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   one-cycle request; op/a/b sampled while high
//   op     in   [3:0] opcode (0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,
//                6 MADD,7 MADDU,8 MSUB,9 MSUBU, 10-15 reserved)
//   a, b   in   [31:0] rs / rt operands
//   flush  in   abort request (only with MD_FLUSH_EN)
//   busy   out  multi-cycle op in flight
//   hi, lo out  [31:0] architectural HI / LO
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MD_FLUSH_EN
  input  logic        flush,
`endif
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        flush_w;

`ifdef MD_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Datapath. op[0] selects the unsigned flavour for every multiply,
  // accumulate and divide opcode, so one select covers them all.
  logic [63:0] acc, prod_s, prod_u, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_n, div_d, uq, ur, quo, rem;

  assign acc    = {hi_q, lo_q};
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign prod   = op[0] ? prod_u : prod_s;

  // Signed division runs on magnitudes through the same unsigned divider.
  // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 / 1, and the
  // quotient sign is positive, giving lo=0x80000000, hi=0.
  assign a_neg = ~op[0] & a[31];
  assign b_neg = ~op[0] & b[31];
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;
  assign div_n = a_mag;
  // Divisor forced nonzero so the divider never sees 0; the result is
  // discarded for b==0 anyway.
  assign div_d = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign uq    = div_n / div_d;
  assign ur    = div_n % div_d;
  assign quo   = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign rem   = a_neg ? (~ur + 32'd1) : ur;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !flush_w) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              {phi_d, plo_d} = prod;
              cnt_d          = 4'(MULT_CYCLES);
              state_d        = RUN;
            end
            OP_MADD, OP_MADDU: begin
              {phi_d, plo_d} = acc + prod;
              cnt_d          = 4'(MULT_CYCLES);
              state_d        = RUN;
            end
            OP_MSUB, OP_MSUBU: begin
              {phi_d, plo_d} = acc - prod;
              cnt_d          = 4'(MULT_CYCLES);
              state_d        = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero still occupies the unit but commits the
              // current HI/LO, leaving them unchanged.
              {phi_d, plo_d} = (b == 32'd0) ? acc : {rem, quo};
              cnt_d          = 4'(DIV_CYCLES);
              state_d        = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // start is ignored here; upstream is required to stall.
        cnt_d = cnt_q - 4'd1;
        if (flush_w) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          phi_d   = 32'd0;
          plo_d   = 32'd0;
        end else if (cnt_q == 4'd1) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
